// File: rtl/wb_to_native_pkg.sv
// wb_to_native_pkg: shared FSM state encoding and lane constants for the Wishbone-to-native bridge
package wb_to_native_pkg;
  localparam int LANES = 8;
  localparam int WB_DW = 32;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_ACK} state_t;
endpackage

// File: rtl/wb_to_native.sv
// wb_to_native: bridges single Wishbone word transfers onto a 256-bit native cmd/wdata/rdata port
// Ports: sys_clk/sys_rst (sync, active-high); wishbone_port_* slave side (cti/bte ignored, err tied 0);
//        cmd_* command out, wdata_* write data out, rdata_* read data in; all first/last flags single-beat.
module wb_to_native
  import wb_to_native_pkg::*;
#(
  parameter int NATIVE_DW = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [ADDR_W-1:0]      wishbone_port_adr,
  input  logic [WB_DW-1:0]       wishbone_port_dat_w,
  output logic [WB_DW-1:0]       wishbone_port_dat_r,
  input  logic [3:0]             wishbone_port_sel,
  input  logic                   wishbone_port_cyc,
  input  logic                   wishbone_port_stb,
  input  logic                   wishbone_port_we,
  input  logic [2:0]             wishbone_port_cti,
  input  logic [1:0]             wishbone_port_bte,
  output logic                   wishbone_port_ack,
  output logic                   wishbone_port_err,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_first,
  output logic                   cmd_last,
  output logic                   cmd_payload_we,
  output logic [ADDR_W-1:0]      cmd_payload_addr,
  output logic                   wdata_valid,
  input  logic                   wdata_ready,
  output logic                   wdata_first,
  output logic                   wdata_last,
  output logic [NATIVE_DW-1:0]   wdata_payload_data,
  output logic [NATIVE_DW/8-1:0] wdata_payload_we,
  input  logic                   rdata_valid,
  output logic                   rdata_ready,
  input  logic                   rdata_first,
  input  logic                   rdata_last,
  input  logic [NATIVE_DW-1:0]   rdata_payload_data
);
  state_t             r_state;
  logic [ADDR_W-1:0]  r_adr;
  logic [WB_DW-1:0]   r_dat;
  logic [WB_DW-1:0]   r_dat_r;
  logic [3:0]         r_sel;
  logic               r_we;
  logic               r_cmd_valid;
  logic               r_wdata_valid;
  logic               r_rdata_ready;
  logic               r_ack;
  logic               w_unused;
  assign w_unused            = &{1'b0, wishbone_port_cti, wishbone_port_bte, rdata_first, rdata_last};
  assign wishbone_port_err   = 1'b0;
  assign cmd_first           = 1'b1;
  assign cmd_last            = 1'b1;
  assign wdata_first         = 1'b1;
  assign wdata_last          = 1'b1;
  assign wishbone_port_ack   = r_ack;
  assign wishbone_port_dat_r = r_dat_r;
  assign cmd_valid           = r_cmd_valid;
  assign cmd_payload_we      = r_we;
  assign cmd_payload_addr    = {3'b000, r_adr[ADDR_W-1:3]};
  assign wdata_valid         = r_wdata_valid;
  assign wdata_payload_data  = {LANES{r_dat}};
  // each 32-bit lane owns 4 byte enables, so the word's selects move by 4 bits per lane index
  assign wdata_payload_we    = {{(NATIVE_DW/8-4){1'b0}}, r_sel} << {r_adr[2:0], 2'b00};
  assign rdata_ready         = r_rdata_ready;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= S_IDLE;
      r_adr         <= '0;
      r_dat         <= '0;
      r_sel         <= '0;
      r_we          <= 1'b0;
      r_dat_r       <= '0;
      r_cmd_valid   <= 1'b0;
      r_wdata_valid <= 1'b0;
      r_rdata_ready <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: if (wishbone_port_cyc && wishbone_port_stb) begin
          r_adr       <= wishbone_port_adr;
          r_dat       <= wishbone_port_dat_w;
          r_sel       <= wishbone_port_sel;
          r_we        <= wishbone_port_we;
          r_cmd_valid <= 1'b1;
          r_state     <= S_CMD;
        end
        S_CMD: if (cmd_ready) begin
          r_cmd_valid   <= 1'b0;
          r_wdata_valid <= r_we;
          r_rdata_ready <= !r_we;
          r_state       <= r_we ? S_WRITE : S_READ;
        end
        S_WRITE: if (wdata_ready) begin
          r_wdata_valid <= 1'b0;
          r_ack         <= 1'b1;
          r_state       <= S_ACK;
        end
        S_READ: if (rdata_valid) begin
          r_rdata_ready <= 1'b0;
          r_dat_r       <= rdata_payload_data[{r_adr[2:0], 5'b00000} +: WB_DW];
          r_ack         <= 1'b1;
          r_state       <= S_ACK;
        end
        S_ACK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_to_native.sv
// tb_wb_to_native: directed and randomized checks of wb_to_native against a word/lane reference model
module tb_wb_to_native;
  logic         sys_clk = 0;
  logic         sys_rst = 1;
  logic [31:0]  wishbone_port_adr = 0;
  logic [31:0]  wishbone_port_dat_w = 0;
  logic [31:0]  wishbone_port_dat_r;
  logic [3:0]   wishbone_port_sel = 0;
  logic         wishbone_port_cyc = 0;
  logic         wishbone_port_stb = 0;
  logic         wishbone_port_we = 0;
  logic [2:0]   wishbone_port_cti = 0;
  logic [1:0]   wishbone_port_bte = 0;
  logic         wishbone_port_ack;
  logic         wishbone_port_err;
  logic         cmd_valid;
  logic         cmd_ready = 1;
  logic         cmd_first;
  logic         cmd_last;
  logic         cmd_payload_we;
  logic [31:0]  cmd_payload_addr;
  logic         wdata_valid;
  logic         wdata_ready = 1;
  logic         wdata_first;
  logic         wdata_last;
  logic [255:0] wdata_payload_data;
  logic [31:0]  wdata_payload_we;
  logic         rdata_valid = 1;
  logic         rdata_ready;
  logic         rdata_first = 1;
  logic         rdata_last = 1;
  logic [255:0] rdata_payload_data = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_rd = 0;
  logic [31:0] words [8];
  always #5 sys_clk = ~sys_clk;
  wb_to_native dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wishbone_port_adr(wishbone_port_adr), .wishbone_port_dat_w(wishbone_port_dat_w),
    .wishbone_port_dat_r(wishbone_port_dat_r), .wishbone_port_sel(wishbone_port_sel),
    .wishbone_port_cyc(wishbone_port_cyc), .wishbone_port_stb(wishbone_port_stb),
    .wishbone_port_we(wishbone_port_we), .wishbone_port_cti(wishbone_port_cti),
    .wishbone_port_bte(wishbone_port_bte), .wishbone_port_ack(wishbone_port_ack),
    .wishbone_port_err(wishbone_port_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_first(cmd_first), .cmd_last(cmd_last),
    .cmd_payload_we(cmd_payload_we), .cmd_payload_addr(cmd_payload_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_first(wdata_first),
    .wdata_last(wdata_last), .wdata_payload_data(wdata_payload_data), .wdata_payload_we(wdata_payload_we),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_first(rdata_first),
    .rdata_last(rdata_last), .rdata_payload_data(rdata_payload_data)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] exp_data(input logic [31:0] d);
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = d;
    return v;
  endfunction
  function automatic logic [31:0] exp_be(input logic [31:0] a, input logic [3:0] s);
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) if (i == a % 8) v[4*i +: 4] = s;
    return v;
  endfunction
  task automatic load_words();
    for (int i = 0; i < 8; i++) begin
      words[i] = $urandom;
      rdata_payload_data[32*i +: 32] = words[i];
    end
  endtask
  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
    @(negedge sys_clk);
    wishbone_port_cyc = 1; wishbone_port_stb = 1; wishbone_port_we = w;
    wishbone_port_adr = a; wishbone_port_dat_w = d; wishbone_port_sel = s;
  endtask
  task automatic drop();
    wishbone_port_cyc = 0; wishbone_port_stb = 0;
    wishbone_port_adr = $urandom; wishbone_port_dat_w = $urandom;
  endtask
  // readies high: cmd seen after the request edge, wdata after the next, ack sampled by the master at request edge + 3
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    request(a, d, s, 1);
    @(negedge sys_clk); drop();
    chk("wr_cmd_valid", cmd_valid, 1);
    chk("wr_cmd_we", cmd_payload_we, 1);
    chk("wr_cmd_addr", cmd_payload_addr, a / 8);
    chk("wr_ack_early", wishbone_port_ack, 0);
    @(negedge sys_clk);
    chk("wr_wdata_valid", wdata_valid, 1);
    chk("wr_cmd_valid_drop", cmd_valid, 0);
    chk("wr_data", wdata_payload_data, exp_data(d));
    chk("wr_be", wdata_payload_we, exp_be(a, s));
    chk("wr_ack_early2", wishbone_port_ack, 0);
    @(negedge sys_clk);
    chk("wr_ack", wishbone_port_ack, 1);
    chk("wr_wdata_valid_drop", wdata_valid, 0);
    @(negedge sys_clk);
    chk("wr_ack_once", wishbone_port_ack, 0);
    chk("wr_dat_r_hold", wishbone_port_dat_r, last_rd);
  endtask
  task automatic rd(input logic [31:0] a);
    load_words();
    request(a, $urandom, 4'hF, 0);
    @(negedge sys_clk); drop();
    chk("rd_cmd_valid", cmd_valid, 1);
    chk("rd_cmd_we", cmd_payload_we, 0);
    chk("rd_cmd_addr", cmd_payload_addr, a / 8);
    @(negedge sys_clk);
    chk("rd_rdata_ready", rdata_ready, 1);
    chk("rd_ack_early", wishbone_port_ack, 0);
    @(negedge sys_clk);
    last_rd = words[a % 8];
    chk("rd_ack", wishbone_port_ack, 1);
    chk("rd_dat_r", wishbone_port_dat_r, last_rd);
    chk("rd_ready_drop", rdata_ready, 0);
    @(negedge sys_clk);
    chk("rd_ack_once", wishbone_port_ack, 0);
  endtask
  initial begin
    int acks;
    int waited;
    repeat (2) @(negedge sys_clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_wdata_valid", wdata_valid, 0);
    chk("rst_rdata_ready", rdata_ready, 0);
    chk("rst_ack", wishbone_port_ack, 0);
    chk("rst_dat_r", wishbone_port_dat_r, 0);
    chk("rst_cmd_addr", cmd_payload_addr, 0);
    chk("err_tied", wishbone_port_err, 0);
    chk("first_last", {cmd_first, cmd_last, wdata_first, wdata_last}, 4'hF);
    sys_rst = 0;
    wr(32'h4000_0000, 32'h1, 4'hF);
    wr(32'h0000_0005, $urandom, 4'h3);
    load_words();
    words[3] = 32'hDEAD_BEEF;
    rdata_payload_data[96 +: 32] = 32'hDEAD_BEEF;
    request(32'h3, 0, 4'hF, 0);
    @(negedge sys_clk); drop();
    repeat (2) @(negedge sys_clk);
    chk("rd_deadbeef_ack", wishbone_port_ack, 1);
    chk("rd_deadbeef", wishbone_port_dat_r, 32'hDEAD_BEEF);
    last_rd = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    chk("rd_deadbeef_once", wishbone_port_ack, 0);
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(1)) wr($urandom, $urandom, 4'($urandom));
      else rd($urandom);
    end
    cmd_ready = 0;
    request(32'h0000_1238, 32'hCAFE_0001, 4'hC, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      wishbone_port_adr = $urandom;
      wishbone_port_we = 0;
      chk("stall_cmd_valid", cmd_valid, 1);
      chk("stall_cmd_addr", cmd_payload_addr, 32'h1238 / 8);
      chk("stall_cmd_we", cmd_payload_we, 1);
      chk("stall_no_ack", wishbone_port_ack, 0);
    end
    cmd_ready = 1;
    waited = 0;
    for (int i = 0; i < 10 && !wishbone_port_ack; i++) begin
      @(negedge sys_clk);
      waited++;
    end
    drop();
    chk("stall_ack_seen", wishbone_port_ack, 1);
    chk("stall_ack_latency", waited, 2);
    @(negedge sys_clk);
    chk("stall_ack_once", wishbone_port_ack, 0);
    rd(32'h11);
    rdata_valid = 0;
    request(32'h22, 0, 4'hF, 0);
    @(negedge sys_clk); drop();
    @(negedge sys_clk);
    chk("rst_mid_in_read", rdata_ready, 1);
    sys_rst = 1;
    @(negedge sys_clk);
    sys_rst = 0;
    rdata_valid = 1;
    chk("rst_mid_rdata_ready", rdata_ready, 0);
    chk("rst_mid_cmd_valid", cmd_valid, 0);
    chk("rst_mid_ack", wishbone_port_ack, 0);
    chk("rst_mid_dat_r", wishbone_port_dat_r, 0);
    chk("rst_mid_addr", cmd_payload_addr, 0);
    last_rd = 0;
    acks = 0;
    repeat (5) begin
      @(negedge sys_clk);
      acks += int'(wishbone_port_ack);
    end
    chk("rst_mid_no_ack", acks, 0);
    rd(32'h7);
    wr(32'h7, $urandom, 4'h9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $fatal(1, "FAIL timeout: simulation did not finish");
  end
endmodule

// File: doc/wb_to_native.md
WB_TO_NATIVE -- requirements
Module: wb_to_native

Interface
REQ-001 Param NATIVE_DW, 256, native data width; SHALL equal 8 x 32-bit Wishbone words.
REQ-002 Param ADDR_W, 32, Wishbone and native address width.
REQ-003 sys_clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 wishbone_port_adr  in  32  word address.
REQ-006 wishbone_port_dat_w  in  32  write data.
REQ-007 wishbone_port_dat_r  out  32  read data.
REQ-008 wishbone_port_sel  in  4  byte selects.
REQ-009 wishbone_port_cyc / wishbone_port_stb / wishbone_port_we  in  1 each  cycle, strobe, write enable.
REQ-010 wishbone_port_cti  in  3, wishbone_port_bte  in  2  burst hints; accepted and ignored.
REQ-011 wishbone_port_ack  out  1  one-cycle transfer acknowledge.
REQ-012 wishbone_port_err  out  1  tied 0.
REQ-013 cmd_valid  out  1, cmd_ready  in  1  native command handshake.
REQ-014 cmd_first / cmd_last  out  1 each  tied 1 (single-beat).
REQ-015 cmd_payload_we  out  1  1 = write; cmd_payload_addr  out  32  native beat address.
REQ-016 wdata_valid  out  1, wdata_ready  in  1  write-data handshake.
REQ-017 wdata_first / wdata_last  out  1 each  tied 1.
REQ-018 wdata_payload_data  out  256; wdata_payload_we  out  32  byte enables.
REQ-019 rdata_valid  in  1, rdata_ready  out  1  read-data handshake.
REQ-020 rdata_first / rdata_last  in  1 each  ignored; rdata_payload_data  in  256.

Function
REQ-021 FSM states IDLE, CMD, WRITE, READ, ACK; a transfer SHALL complete via the handshakes below.
REQ-022 IDLE: when cyc&stb sampled high, latch adr, dat_w, sel, we; go CMD. Requests are latched, so a one-cycle stb pulse SHALL still complete.
REQ-023 CMD: cmd_valid=1 with cmd_payload_we=latched we and cmd_payload_addr={3'b000, adr[31:3]}. On cmd_ready: go WRITE if we, else READ.
REQ-024 WRITE: wdata_valid=1; data = dat_w replicated in all 8 lanes; wdata_payload_we = sel << (4*adr[2:0]), other bits 0. On wdata_ready: go ACK.
REQ-025 READ: rdata_ready=1. On rdata_valid: register dat_r = rdata_payload_data[32*adr[2:0] +: 32]; go ACK.
REQ-026 ACK: wishbone_port_ack=1 for exactly one cycle, whether or not cyc is still high; go IDLE.
REQ-027 Stall behaviour: valid outputs SHALL hold, with payload stable, until the matching ready/valid is seen; no timeout.
REQ-028 Latency with ready/valid already high: write ack 3 cycles after the request edge; read ack 3 cycles after the request edge.
REQ-029 dat_r SHALL hold its last read value until the next read completes.
REQ-030 Only one outstanding transfer; cyc&stb seen outside IDLE SHALL be ignored.

Reset
REQ-031 sys_rst SHALL force IDLE with all valid/ready/ack outputs 0, dat_r 0 and latched request registers 0, including mid-transfer; the aborted transfer SHALL NOT be acked.

Structure
REQ-032 Put the FSM state enum and the lane-count constant (8) in a shared package, wb_to_native_pkg.
REQ-033 Implement as a single module with no sub-modules.

Verification
REQ-034 Write: adr=0x40000000, dat_w=0x1, sel=0xF, 1-cycle stb, readies=1 -> cmd addr=0x08000000, we=1; wdata lane0=0x1; byte enables=0x0000000F; one ack pulse.
REQ-035 Write: adr=0x00000005, sel=0x3 -> cmd addr=0; byte enables=0x00300000.
REQ-036 Read: adr=0x00000003, rdata_valid returns word3=0xDEADBEEF -> dat_r=0xDEADBEEF, ack 1 cycle.
REQ-037 Stall: cmd_ready=0 for 5 cycles -> cmd_valid and address hold; ack only after ready.
REQ-038 Reset asserted in READ -> outputs 0 next cycle, no ack, next request handled normally.
